// File: rtl/rate_detector.sv
// Rate detector: recovers a 2-bit speed code from the spacing of enable
// pulses, locking after two consecutive matching intervals.
module rate_detector #(
    parameter  int CLOCK_FREQUENCY = 4,
    localparam int W               = $clog2(4 * CLOCK_FREQUENCY) + 1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Pulse,
    output logic [1:0]   SpeedOut,
    output logic         Valid,
    output logic         Error,
    output logic [W-1:0] Period
);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam logic [W-1:0] P_ONE  = W'(1);
    localparam logic [W-1:0] P_1F   = W'(CLOCK_FREQUENCY);
    localparam logic [W-1:0] P_2F   = W'(2 * CLOCK_FREQUENCY);
    localparam logic [W-1:0] P_4F   = W'(4 * CLOCK_FREQUENCY);

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [1:0]     cand_q, cand_d;
    logic           cand_vld_q, cand_vld_d;
    logic [1:0]     speed_q, speed_d;
    logic           valid_q, valid_d;
    logic           error_q, error_d;
    logic [W-1:0]   period_q, period_d;

    logic [1:0]     code;
    logic           code_legal;

    // The measured period is the counter value seen in the pulse cycle.
    always_comb begin
        code       = 2'd0;
        code_legal = 1'b1;
        if (cnt_q == P_ONE)      code = 2'd0;
        else if (cnt_q == P_1F)  code = 2'd1;
        else if (cnt_q == P_2F)  code = 2'd2;
        else if (cnt_q == P_4F)  code = 2'd3;
        else                     code_legal = 1'b0;
    end

    // NOTE: every next-state signal gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        speed_d    = speed_q;
        valid_d    = valid_q;
        error_d    = 1'b0;
        period_d   = period_q;

        // Interval counter restarts on each pulse and saturates at 4F.
        if (Pulse)               cnt_d = P_ONE;
        else if (cnt_q != P_4F)  cnt_d = cnt_q + P_ONE;
        else                     cnt_d = cnt_q;

        unique case (state_q)
            S_SEARCH: begin
                if (Pulse) begin
                    state_d    = S_MEASURE;
                    cand_d     = 2'd0;
                    cand_vld_d = 1'b0;
                end
            end

            S_MEASURE: begin
                if (Pulse) begin
                    period_d = cnt_q;
                    if (!code_legal) begin
                        cand_vld_d = 1'b0;
                        error_d    = 1'b1;
                    end else if (cand_vld_q && (cand_q == code)) begin
                        state_d = S_LOCKED;
                        speed_d = code;
                        valid_d = 1'b1;
                    end else begin
                        cand_d     = code;
                        cand_vld_d = 1'b1;
                    end
                end else if (cnt_q == P_4F) begin
                    state_d    = S_SEARCH;
                    valid_d    = 1'b0;
                    error_d    = 1'b1;
                    cand_vld_d = 1'b0;
                end
            end

            S_LOCKED: begin
                if (Pulse) begin
                    period_d = cnt_q;
                    // A differing interval drops lock but may seed the next candidate.
                    if (!code_legal || (code != speed_q)) begin
                        state_d    = S_MEASURE;
                        valid_d    = 1'b0;
                        error_d    = 1'b1;
                        cand_d     = code;
                        cand_vld_d = code_legal;
                    end
                end else if (cnt_q == P_4F) begin
                    state_d    = S_SEARCH;
                    valid_d    = 1'b0;
                    error_d    = 1'b1;
                    cand_vld_d = 1'b0;
                end
            end

            default: begin
                state_d    = S_SEARCH;
                valid_d    = 1'b0;
                cand_vld_d = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values; reset is synchronous and clears all of them.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_SEARCH;
            cnt_q      <= '0;
            cand_q     <= 2'd0;
            cand_vld_q <= 1'b0;
            speed_q    <= 2'd0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
            speed_q    <= speed_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            period_q   <= period_d;
        end
    end

    assign SpeedOut = speed_q;
    assign Valid    = valid_q;
    assign Error    = error_q;
    assign Period   = period_q;

endmodule

// File: tb/tb_rate_detector.sv
// Self-checking bench for rate_detector: directed scenarios plus randomized
// pulse trains compared against a time-stamp based reference model.
module tb_rate_detector;

    localparam int F = 4;
    localparam int W = $clog2(4 * F) + 1;

    logic         Clock;
    logic         Reset;
    logic         Pulse;
    logic [1:0]   SpeedOut;
    logic         Valid;
    logic         Error;
    logic [W-1:0] Period;

    int n_cmp = 0;
    int n_bad = 0;

    rate_detector #(.CLOCK_FREQUENCY(F)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Pulse    (Pulse),
        .SpeedOut (SpeedOut),
        .Valid    (Valid),
        .Error    (Error),
        .Period   (Period)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: remembers when the reference pulse happened and the
    // list of recognised codes since the last disturbance.
    int  cyc = 0;
    int  ref_cyc = 0;
    bit  has_ref = 0;
    int  hist[$];
    bit  m_locked = 0;
    int  m_speed = 0;
    int  m_period = 0;
    bit  m_error = 0;

    function automatic int classify(input int p);
        if (p == 1)     return 0;
        if (p == F)     return 1;
        if (p == 2 * F) return 2;
        if (p == 4 * F) return 3;
        return -1;
    endfunction

    function automatic void model_edge(input bit rst, input bit pul);
        int p;
        int c;
        m_error = 0;
        if (rst) begin
            has_ref = 0; hist.delete(); m_locked = 0; m_speed = 0; m_period = 0;
        end else if (!has_ref) begin
            if (pul) begin has_ref = 1; ref_cyc = cyc; hist.delete(); end
        end else if (pul) begin
            p = cyc - ref_cyc;
            ref_cyc = cyc;
            m_period = p;
            c = classify(p);
            if (m_locked) begin
                if (c != m_speed) begin
                    m_locked = 0; m_error = 1; hist.delete();
                    if (c >= 0) hist.push_back(c);
                end
            end else if (c < 0) begin
                m_error = 1; hist.delete();
            end else if (hist.size() > 0 && hist[$] == c) begin
                m_locked = 1; m_speed = c;
            end else begin
                hist.push_back(c);
            end
        end else if (cyc - ref_cyc >= 4 * F) begin
            has_ref = 0; m_locked = 0; m_error = 1; hist.delete();
        end
        cyc++;
    endfunction

    // Drive on the falling edge, advance the model at the rising edge and
    // leave time 1 unit after it for outputs to be sampled.
    task automatic step(input bit pul, input bit rst);
        @(negedge Clock);
        Pulse = pul;
        Reset = rst;
        @(posedge Clock);
        model_edge(rst, pul);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    function automatic logic [W+3:0] obs();
        return {Valid, SpeedOut, Error, Period};
    endfunction

    task automatic test_reset();
        logic [W+3:0] exp;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        exp = '0;
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", obs(), exp);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_speed2_train();
        logic [W+3:0] exp;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n_cmp++;
        if (Error !== 1'b0 || Period !== '0) begin
            n_bad++;
            $display("FAIL search_first_pulse: err=%b period=%0d expected 0/0", Error, Period);
        end
        idle(7); step(1'b1, 1'b0);
        n_cmp++;
        if (Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL speed2_second_pulse: valid=%b expected 0", Valid);
        end
        idle(7); step(1'b1, 1'b0);
        exp = {1'b1, 2'd2, 1'b0, W'(8)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL speed2_lock: got %h expected %h", obs(), exp);
        end
        idle(7); step(1'b1, 1'b0);
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL speed2_stable: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_continuous();
        logic [W+3:0] exp;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_cmp++;
        if (Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL continuous_early: valid=%b expected 0", Valid);
        end
        step(1'b1, 1'b0);
        exp = {1'b1, 2'd0, 1'b0, W'(1)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL continuous_lock: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_relock();
        logic [W+3:0] exp;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0); idle(3);
        step(1'b1, 1'b0); idle(3);
        step(1'b1, 1'b0);
        exp = {1'b1, 2'd1, 1'b0, W'(4)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL relock_first: got %h expected %h", obs(), exp);
        end
        idle(15); step(1'b1, 1'b0);
        exp = {1'b0, 2'd1, 1'b1, W'(16)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL relock_break: got %h expected %h", obs(), exp);
        end
        idle(1);
        n_cmp++;
        if (Error !== 1'b0) begin
            n_bad++;
            $display("FAIL relock_error_width: err=%b expected 0", Error);
        end
        idle(14); step(1'b1, 1'b0);
        exp = {1'b1, 2'd3, 1'b0, W'(16)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL relock_speed3: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_timeout();
        logic [W+3:0] exp;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0); idle(15);
        step(1'b1, 1'b0); idle(15);
        step(1'b1, 1'b0);
        idle(15);
        exp = {1'b1, 2'd3, 1'b0, W'(16)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL timeout_early: got %h expected %h", obs(), exp);
        end
        idle(1);
        exp = {1'b0, 2'd3, 1'b1, W'(16)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL timeout_fire: got %h expected %h", obs(), exp);
        end
        idle(1);
        n_cmp++;
        if (Error !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_error_width: err=%b expected 0", Error);
        end
        idle(3); step(1'b1, 1'b0);
        exp = {1'b0, 2'd3, 1'b0, W'(16)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL timeout_in_search: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_illegal();
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(4); step(1'b1, 1'b0);
            n_cmp++;
            if (Error !== 1'b1 || Valid !== 1'b0 || Period !== W'(5)) begin
                n_bad++;
                $display("FAIL illegal5_%0d: err=%b valid=%b period=%0d expected 1/0/5",
                         k, Error, Valid, Period);
            end
        end
        idle(1);
        n_cmp++;
        if (Error !== 1'b0 || Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal5_after: err=%b valid=%b expected 0/0", Error, Valid);
        end
    endtask

    task automatic test_reset_midlock();
        logic [W+3:0] exp;
        step(1'b0, 1'b1);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        exp = '0;
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL midlock_reset: got %h expected %h", obs(), exp);
        end
        step(1'b1, 1'b0); step(1'b1, 1'b0);
        n_cmp++;
        if (Valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midlock_early_relock: valid=%b expected 0", Valid);
        end
        step(1'b1, 1'b0);
        exp = {1'b1, 2'd0, 1'b0, W'(1)};
        n_cmp++;
        if (obs() !== exp) begin
            n_bad++;
            $display("FAIL midlock_relock: got %h expected %h", obs(), exp);
        end
    endtask

    task automatic test_random();
        int sel;
        int k;
        int reps;
        logic [W+3:0] exp;
        step(1'b0, 1'b1);
        for (int b = 0; b < 250; b++) begin
            sel  = int'($urandom_range(0, 19));
            reps = 1;
            if (sel < 12) begin
                case ($urandom_range(0, 3))
                    0:       k = 1;
                    1:       k = F;
                    2:       k = 2 * F;
                    default: k = 4 * F;
                endcase
                reps = int'($urandom_range(1, 4));
            end else if (sel < 16) begin
                k = int'($urandom_range(1, 4 * F));
            end else if (sel < 19) begin
                k = int'($urandom_range(4 * F + 1, 4 * F + 6));
            end else begin
                k = 0;
            end
            for (int r = 0; r < reps; r++) begin
                if (k == 0) begin
                    step(1'($urandom_range(0, 1)), 1'b1);
                end else begin
                    for (int i = 0; i < k; i++) begin
                        step(i == 0, 1'b0);
                        exp = {m_locked, 2'(m_speed), m_error, W'(m_period)};
                        n_cmp++;
                        if (obs() !== exp) begin
                            n_bad++;
                            $display("FAIL random_b%0d_i%0d: got %h expected %h", b, i, obs(), exp);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        Pulse = 1'b0;
        test_reset();
        test_speed2_train();
        test_continuous();
        test_relock();
        test_timeout();
        test_illegal();
        test_reset_midlock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rate_detector.md
RATE_DETECTOR -- requirements
Module: rate_detector

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 4, giving enable-pulse cycles per Speed-1 period; legal values are 2 or more.
REQ-002 SHALL have local width W = clog2(4*CLOCK_FREQUENCY)+1 for interval and period values.
REQ-003 SHALL have port Clock, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port Pulse, input, 1 bit: rate-divider enable stream; each high cycle is one pulse event.
REQ-006 SHALL have port SpeedOut, output, 2 bits: recovered Speed code; meaningful only while Valid=1.
REQ-007 SHALL have port Valid, output, 1 bit: high while in LOCKED.
REQ-008 SHALL have port Error, output, 1 bit: one-cycle flag for mismatch, illegal interval or timeout.
REQ-009 SHALL have port Period, output, W bits: most recently measured pulse interval in Clock cycles.

Function
REQ-010 SHALL implement three states: SEARCH (no reference pulse), MEASURE (reference pulse held, not locked) and LOCKED.
REQ-011 SHALL hold an interval counter cnt (W bits); period = value of cnt in a cycle where Pulse=1.
- cnt is loaded to 1 on every Pulse.
- Otherwise cnt increments by 1.
REQ-012 SHALL classify a period p as follows; any other p is illegal.
- p=1 -> code 0.
- p=F -> code 1.
- p=2F -> code 2.
- p=4F -> code 3.
REQ-013 SHALL, in SEARCH with Pulse=1, load cnt=1, clear the candidate, and go to MEASURE; no classification and no Period update.
REQ-014 SHALL, in MEASURE/LOCKED with Pulse=1, register Period<=p on the next edge.
REQ-015 SHALL, in MEASURE with a legal code c:
- if candidate valid and cand==c: go to LOCKED, SpeedOut<=c, Valid<=1;
- else: cand<=c, candidate valid<=1.
REQ-016 SHALL, in MEASURE with an illegal p: clear candidate valid, assert Error for one cycle, and stay in MEASURE.
REQ-017 SHALL, in LOCKED with code == SpeedOut: stay LOCKED with no output change other than Period.
REQ-018 SHALL, in LOCKED with a different legal code c or an illegal p, for one cycle:
- go to MEASURE, Valid<=0, Error<=1;
- cand<=c with candidate valid<=1 if c is legal, else candidate valid<=0.
REQ-019 SHALL, in MEASURE/LOCKED with Pulse=0 and cnt==4F (timeout), for one cycle:
- go to SEARCH, Valid<=0, Error<=1, candidate valid<=0;
- cnt holds and never exceeds 4F.
REQ-020 SHALL give Pulse precedence over timeout in the same cycle, so a period of 4F is legal.
REQ-021 SHALL register all outputs, responding on the edge after the deciding Pulse.
- Lock asserts Valid one cycle after the third pulse of a steady train.
REQ-022 SHALL hold SpeedOut unchanged when leaving LOCKED, with Valid=0 marking it stale.
REQ-023 SHALL assert Error for exactly one cycle per event, and never in SEARCH.

Reset
REQ-024 SHALL, on Reset=1 at a rising edge, regardless of state or Pulse:
- state<=SEARCH, cnt<=0, candidate valid<=0;
- SpeedOut<=0, Valid<=0, Error<=0, Period<=0.
REQ-025 SHALL ignore Pulse in the Reset cycle; the first pulse after deassertion is treated as in SEARCH.

Verification (F=4)
REQ-026 SHALL cover a pulse every 8 cycles from reset: Valid=1, SpeedOut=2, Period=8 one cycle after the 3rd pulse, then stable.
REQ-027 SHALL cover Pulse held high continuously: lock with SpeedOut=0, Period=1 after the 3rd high cycle.
REQ-028 SHALL cover a lock at period 4 followed by one interval of 16:
- next cycle Valid=0, Error=1 for one cycle;
- one further interval of 16 relocks with SpeedOut=3.
REQ-029 SHALL cover a lock at period 16 followed by Pulse stuck low: Error=1 and Valid=0 on the cycle after cnt reaches 16 without a pulse; state SEARCH.
REQ-030 SHALL cover intervals of 5 repeated: Error pulses after each interval and Valid never rises.
REQ-031 SHALL cover Reset asserted mid-lock coincident with Pulse: all outputs 0 next cycle, and a fresh 3-pulse train is needed to relock.
